// File: rtl/sqrt_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | sqrt_ctrl_pkg                                                            |
// | Shared types and helpers for the square-root request arbiter.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package sqrt_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic int sqrt_iter(input int width, input int fbits);
    return (width + fbits + 1) / 2;
  endfunction

  function automatic int sqrt_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | rr_arbiter                                                               |
// | Round-robin grant; SQRT_ARB_FIXED_PRIO_EN selects lowest-index priority. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter
  import sqrt_ctrl_pkg::*;
#(
  parameter int  N_REQ = 4,
  localparam int ID_W  = sqrt_id_w(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx
);

  logic            found;
  logic [ID_W-1:0] cand;

`ifdef SQRT_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ID_W'(i);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end
`else
  logic [ID_W-1:0] last_q, last_d;
  int              k;

  // Search begins one past the most recent winner and wraps.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    k     = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      k = int'(last_q) + i;
      if (k >= N_REQ) k = k - N_REQ;
      cand = ID_W'(k);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
    last_d = (en && found) ? idx : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= ID_W'(N_REQ - 1);
    else     last_q <= last_d;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/sqrtFixedPoint.sv
// +--------------------------------------------------------------------------+
// | sqrtFixedPoint                                                           |
// | Iterative digit-by-digit square root, one root bit per busy cycle.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module sqrtFixedPoint
  import sqrt_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FBITS = 0
) (
  input  logic             clk,
  input  logic             start,
  input  logic [WIDTH-1:0] rad,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] root,
  output logic [WIDTH-1:0] rem
);

  localparam int ITER = sqrt_iter(WIDTH, FBITS);
  localparam int RW   = 2 * ITER;
  localparam int AW   = ITER + 2;
  localparam int CW   = $clog2(ITER + 1);

  logic [RW-1:0]   x_q, x_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [ITER-1:0] root_q, root_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic [AW+1:0]   acc_sh, trial;

  always_comb begin
    x_d     = x_q;
    acc_d   = acc_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    acc_sh  = {acc_q, x_q[RW-1 -: 2]};
    trial   = {2'b00, root_q, 2'b01};
    if (start) begin
      x_d     = RW'(rad) << FBITS;
      acc_d   = '0;
      root_d  = '0;
      cnt_d   = CW'(ITER);
      busy_d  = 1'b1;
      valid_d = 1'b0;
    end else if (busy_q) begin
      x_d = x_q << 2;
      if (acc_sh >= trial) begin
        acc_d  = AW'(acc_sh - trial);
        root_d = {root_q[ITER-2:0], 1'b1};
      end else begin
        acc_d  = AW'(acc_sh);
        root_d = {root_q[ITER-2:0], 1'b0};
      end
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d  = 1'b0;
        valid_d = 1'b1;
      end
    end
  end

  // No reset: an interrupted computation simply runs to completion.
  always_ff @(posedge clk) begin
    x_q     <= x_d;
    acc_q   <= acc_d;
    root_q  <= root_d;
    cnt_q   <= cnt_d;
    busy_q  <= busy_d;
    valid_q <= valid_d;
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign root  = WIDTH'(root_q);
  assign rem   = WIDTH'(acc_q);

endmodule

`default_nettype wire

// File: rtl/sqrt_req_arbiter.sv
// +--------------------------------------------------------------------------+
// | sqrt_req_arbiter                                                         |
// | Shares one sqrtFixedPoint core between N_REQ requesters with a tagged    |
// | response channel. Option macro: SQRT_ARB_FIXED_PRIO_EN.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module sqrt_req_arbiter
  import sqrt_ctrl_pkg::*;
#(
  parameter int  N_REQ = 4,
  parameter int  WIDTH = 8,
  parameter int  FBITS = 0,
  localparam int ID_W  = sqrt_id_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_rad,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_root,
  output logic [WIDTH-1:0]       rsp_rem
);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  rad_q, rad_d;
  logic [WIDTH-1:0]  root_q, root_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [ID_W-1:0]   id_q, id_d;

  logic              arb_en;
  logic [N_REQ-1:0]  arb_gnt;
  logic [ID_W-1:0]   arb_idx;
  logic [WIDTH-1:0]  win_rad;
  logic              core_start, core_busy, core_valid;
  logic [WIDTH-1:0]  core_root, core_rem;

  // Grants wait for an orphaned computation (left by a reset) to drain.
  assign arb_en     = (state_q == ST_IDLE) && !core_busy && !rst;
  assign req_ready  = arb_en ? arb_gnt : '0;
  assign win_rad    = req_rad[arb_idx*WIDTH +: WIDTH];
  assign core_start = (state_q == ST_ISSUE);

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_valid),
    .en  (arb_en),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  sqrtFixedPoint #(.WIDTH(WIDTH), .FBITS(FBITS)) u_core (
    .clk   (clk),
    .start (core_start),
    .rad   (rad_q),
    .busy  (core_busy),
    .valid (core_valid),
    .root  (core_root),
    .rem   (core_rem)
  );

  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    id_d    = id_q;
    root_d  = root_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_en && |arb_gnt) begin
          rad_d   = win_rad;
          id_d    = arb_idx;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (core_valid && !core_busy) begin
          root_d  = core_root;
          rem_d   = core_rem;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rad_q   <= '0;
      id_q    <= '0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      id_q    <= id_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = id_q;
  assign rsp_root  = root_q;
  assign rsp_rem   = rem_q;

endmodule

`default_nettype wire

// File: tb/tb_sqrt_req_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_sqrt_req_arbiter                                                      |
// | Self-checking bench: vector table, corner sequences, random vs model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sqrt_req_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int FBITS = 0;
  localparam int ID_W  = 2;
  localparam int ITER  = 4;
  localparam int LAT   = ITER + 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid, req_ready;
  logic [N_REQ*WIDTH-1:0] req_rad;
  logic                   rsp_valid, rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_root, rsp_rem;

  sqrt_req_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .FBITS(FBITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rad   (req_rad),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_root  (rsp_root),
    .rsp_rem   (rsp_rem)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int model_last;
  int prad[N_REQ];

  typedef struct { int id; int rad; int root; int rem; } vec_t;
  typedef struct { int id; int root; int rem; } rsp_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic int irem(input int x);
    return x - isqrt(x) * isqrt(x);
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input int i);
    return N_REQ'(1) << i;
  endfunction

  // Reference arbitration taken straight from the grant rules.
  function automatic int pick(input logic [N_REQ-1:0] m, input int last);
`ifdef SQRT_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N_REQ; i++) if (m[i]) return i;
`else
    for (int i = 1; i <= N_REQ; i++) if (m[(last + i) % N_REQ]) return (last + i) % N_REQ;
`endif
    return -1;
  endfunction

  task automatic set_rad(input int k, input int v);
    req_rad[k*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_last = N_REQ - 1;
  endtask

  task automatic wait_ready(input int bound, output int n);
    n = 0;
    while (req_ready == '0 && n < bound) begin @(negedge clk); #1; n++; end
    if (req_ready == '0) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input int bound, output int n);
    n = 0;
    while (!rsp_valid && n < bound) begin @(negedge clk); #1; n++; end
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
  endtask

  // One isolated request: grant in cycle 0, response first visible in cycle LAT.
  task automatic run_txn(input vec_t v);
    int n, lat, extra;
    @(negedge clk);
    req_valid = onehot(v.id); set_rad(v.id, v.rad); rsp_ready = 1'b1;
    #1;
    wait_ready(10, n);
    chk("txn_grant", req_ready, onehot(v.id));
    @(negedge clk); req_valid = '0; #1;
    lat = 1; extra = 0;
    while (!rsp_valid && lat < 30) begin
      if (req_ready != '0) extra++;
      @(negedge clk); #1; lat++;
    end
    chk("txn_latency", lat, LAT);
    chk("txn_id", rsp_id, v.id);
    chk("txn_root", rsp_root, v.root);
    chk("txn_rem", rsp_rem, v.rem);
    chk("txn_no_grant_busy", extra, 0);
  endtask

  // Several requesters held valid; the grant order comes from the model.
  task automatic contend(input logic [N_REQ-1:0] mask, input int n_acc);
    int n, e, last_acc;
    @(negedge clk);
    req_valid = mask; rsp_ready = 1'b1;
    for (int k = 0; k < N_REQ; k++) set_rad(k, prad[k]);
    #1;
    last_acc = 0;
    for (int t = 0; t < n_acc; t++) begin
      wait_ready(20, n);
      e = pick(mask, model_last);
      chk("contend_grant", req_ready, onehot(e));
      if (t > 0) chk("contend_period", cyc - last_acc, ITER + 4);
      last_acc = cyc; model_last = e;
      @(negedge clk); #1;
      wait_rsp(20, n);
      chk("contend_id", rsp_id, e);
      chk("contend_root", rsp_root, isqrt(prad[e]));
      chk("contend_rem", rsp_rem, irem(prad[e]));
    end
    @(negedge clk); req_valid = '0;
  endtask

  vec_t vecs[8];
  rsp_t q[$];

  initial begin
    int n, e, c0, acc, stale, bad, pulses, done, iter, gl;
    logic [N_REQ-1:0] pend;
    rsp_t r;

    vecs[0] = '{2, 'h51, 9, 0};
    vecs[1] = '{0, 'h00, 0, 0};
    vecs[2] = '{3, 'hFF, 15, 30};
    vecs[3] = '{1, 'h10, 4, 0};
    vecs[4] = '{0, 'h11, 4, 1};
    vecs[5] = '{1, 'h19, 5, 0};
    vecs[6] = '{2, 'h02, 1, 1};
    vecs[7] = '{3, 'hC8, 14, 4};

    // Reset state, with requests pending while reset is held.
    rst = 1'b1; req_valid = '0; req_rad = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    req_valid = '1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_root", rsp_root, 0);
    chk("rst_rsp_rem", rsp_rem, 0);
    @(negedge clk); rst = 1'b0; req_valid = '0; model_last = N_REQ - 1;

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Fairness from reset: all four contend.
    do_reset();
    prad[0] = 'h10; prad[1] = 'h11; prad[2] = 'h19; prad[3] = 'hFF;
    contend(4'b1111, 5);

    // Backpressure: response held, queued requester must not be granted.
    @(negedge clk);
    req_valid = 4'b0010; set_rad(1, 'h19); rsp_ready = 1'b0;
    #1;
    wait_ready(20, n);
    chk("bp_grant", req_ready, 4'b0010);
    @(negedge clk); req_valid = 4'b1000; set_rad(3, 'hFF); #1;
    pulses = 0; n = 0;
    while (!rsp_valid && n < 30) begin
      if (req_ready != '0) pulses++;
      @(negedge clk); #1; n++;
    end
    bad = 0;
    for (int t = 0; t < 20; t++) begin
      if (!rsp_valid || rsp_id != 2'd1 || rsp_root != 8'd5 || rsp_rem != 8'd0) bad++;
      if (req_ready != '0) pulses++;
      @(negedge clk); #1;
    end
    chk("bp_hold_stable", bad, 0);
    chk("bp_no_grant", pulses, 0);
    @(negedge clk); rsp_ready = 1'b1; #1;
    chk("bp_exit_rsp_valid", rsp_valid, 1);
    chk("bp_exit_no_same_cycle_grant", req_ready, 0);
    @(negedge clk); #1;
    chk("bp_accept_after_handshake", req_ready, 4'b1000);
    @(negedge clk); req_valid = '0; #1;
    wait_rsp(20, n);
    chk("bp_next_id", rsp_id, 3);
    chk("bp_next_root", rsp_root, 15);
    chk("bp_next_rem", rsp_rem, 30);

    // Reset in the middle of WAIT; the core drains before the next grant.
    do_reset();
    @(negedge clk); req_valid = 4'b0010; set_rad(1, 'hC8); rsp_ready = 1'b1; #1;
    wait_ready(20, n);
    chk("rw_grant", req_ready, 4'b0010);
    c0 = cyc; stale = 0; acc = -1;
    for (int t = 0; t < 20 && acc < 0; t++) begin
      @(negedge clk);
      rst = (cyc - c0 == 3);
      #1;
      if (rsp_valid) stale++;
      if (req_ready != '0) begin
        acc = cyc - c0;
        chk("rw_regrant", req_ready, 4'b0010);
      end
    end
    rst = 1'b0;
    model_last = 1;
    chk("rw_regrant_cycle", acc, ITER + 2);
    chk("rw_no_stale_rsp", stale, 0);
    @(negedge clk); req_valid = '0; #1;
    wait_rsp(20, n);
    chk("rw_id", rsp_id, 1);
    chk("rw_root", rsp_root, 14);
    chk("rw_rem", rsp_rem, 4);

    // Requesters 0 and 3 both held valid.
    do_reset();
    prad[0] = 'h24; prad[3] = 'h40;
    contend(4'b1001, 4);

    // Random traffic and random backpressure against the model.
    do_reset();
    pend = '0; gl = -1; done = 0; iter = 0;
    while (done < 40 && iter < 6000) begin
      @(negedge clk); iter++;
      if (gl >= 0) pend[gl] = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k] = 1'b1;
          prad[k] = int'($urandom_range(0, 255));
          set_rad(k, prad[k]);
        end
      end
      req_valid = pend;
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      gl = -1;
      if (req_ready != '0) begin
        e = pick(pend, model_last);
        if (e < 0) chk("rand_spurious_grant", req_ready, 0);
        else begin
          chk("rand_grant", req_ready, onehot(e));
          model_last = e; gl = e;
          q.push_back('{e, isqrt(prad[e]), irem(prad[e])});
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) chk("rand_unexpected_rsp", 1, 0);
        else begin
          r = q.pop_front();
          chk("rand_id", rsp_id, r.id);
          chk("rand_root", rsp_root, r.root);
          chk("rand_rem", rsp_rem, r.rem);
        end
        done++;
      end
    end
    if (done < 40) chk("rand_timeout", done, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
